// File: rtl/cpu_prefetch_if.sv
`default_nettype none
// ============================================================================
// cpu_prefetch_if : fetch-bus and IR handshake bundle for cpu_prefetch_unit
// Rev 1.0
// ============================================================================
interface cpu_prefetch_if;
   logic        pipeline_advance;
   logic        flush;
   logic [31:0] flush_pc;
   logic        flush_thumb;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] IR;
   logic        ir_valid;
   logic [31:0] ir_pc;
   logic        thumb;

   modport master (
      input  pipeline_advance, flush, flush_pc, flush_thumb, mem_ready, mem_rdata,
      output mem_req, mem_addr, mem_size, IR, ir_valid, ir_pc, thumb
   );

   modport slave (
      output pipeline_advance, flush, flush_pc, flush_thumb, mem_ready, mem_rdata,
      input  mem_req, mem_addr, mem_size, IR, ir_valid, ir_pc, thumb
   );
endinterface
`default_nettype wire

// File: rtl/cpu_prefetch_unit.sv
`default_nettype none
// ============================================================================
// cpu_prefetch_unit : ARM/Thumb instruction prefetch with FIFO, IR stage, flush/drain
// Rev 1.0
// ============================================================================
module cpu_prefetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          FIFO_DEPTH   = 2
) (
   input  logic           clk,
   input  logic           reset,
   cpu_prefetch_if.master bus
);
   localparam int               c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int               c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(FIFO_DEPTH - 1);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         fetch_pc_q, fetch_pc_d;
   logic [31:0]         target_q, target_d;
   logic                thumb_q, thumb_d;
   logic [1:0]          drain_size_q, drain_size_d;

   logic [31:0]         fifo_op_q [FIFO_DEPTH];
   logic [31:0]         fifo_pc_q [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  rd_ptr_q, wr_ptr_q;
   logic [c_cnt_w-1:0]  count_q;
   logic [31:0]         ir_q, ir_pc_q;
   logic                ir_valid_q;

   logic                w_mem_req;
   logic [1:0]          w_mem_size;
   logic [31:0]         w_flush_target;
   logic [15:0]         w_half;
   logic [31:0]         w_push_op;
   logic                w_push;
   logic                w_pop;
   logic                w_unused;

   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last) ? '0 : p + 1'b1;
   endfunction

   // Thumb halfword lane follows the fetch address, ARM takes the whole word
   assign w_half    = fetch_pc_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
   assign w_push_op = thumb_q ? {16'h0000, w_half} : bus.mem_rdata;
   assign w_pop     = bus.pipeline_advance && (count_q != '0) && !bus.flush;
   assign w_unused  = bus.flush_pc[0];

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      target_d       = target_q;
      thumb_d        = thumb_q;
      drain_size_d   = drain_size_q;
      w_mem_req      = 1'b0;
      w_mem_size     = thumb_q ? 2'b01 : 2'b10;
      w_push         = 1'b0;
      w_flush_target = bus.flush_thumb ? {bus.flush_pc[31:1], 1'b0}
                                       : {bus.flush_pc[31:2], 2'b00};
      if (!reset) begin
         case (state_q)
            ST_FETCH: begin
               w_mem_req = (count_q < c_depth);
               if (bus.flush) begin
                  thumb_d = bus.flush_thumb;
                  // An accepted request cannot be withdrawn: let it finish in DRAIN
                  if (w_mem_req && !bus.mem_ready) begin
                     state_d      = ST_DRAIN;
                     target_d     = w_flush_target;
                     drain_size_d = w_mem_size;
                  end else begin
                     fetch_pc_d = w_flush_target;
                  end
               end else if (w_mem_req && bus.mem_ready) begin
                  w_push     = 1'b1;
                  fetch_pc_d = fetch_pc_q + (thumb_q ? 32'd2 : 32'd4);
               end
            end
            ST_DRAIN: begin
               w_mem_req  = 1'b1;
               w_mem_size = drain_size_q;
               if (bus.flush) begin
                  thumb_d  = bus.flush_thumb;
                  target_d = w_flush_target;
               end
               if (bus.mem_ready) begin
                  state_d    = ST_FETCH;
                  fetch_pc_d = bus.flush ? w_flush_target : target_q;
               end
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         fetch_pc_q   <= RESET_VECTOR;
         target_q     <= RESET_VECTOR;
         thumb_q      <= 1'b0;
         drain_size_q <= 2'b10;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         target_q     <= target_d;
         thumb_q      <= thumb_d;
         drain_size_q <= drain_size_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_op_q[wr_ptr_q] <= w_push_op;
         fifo_pc_q[wr_ptr_q] <= fetch_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_q       <= 32'h0;
         ir_pc_q    <= 32'h0;
         ir_valid_q <= 1'b0;
      end else if (bus.flush) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
         if (bus.pipeline_advance) begin
            if (count_q != '0) begin
               ir_q       <= fifo_op_q[rd_ptr_q];
               ir_pc_q    <= fifo_pc_q[rd_ptr_q];
               ir_valid_q <= 1'b1;
            end else begin
               ir_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.mem_req  = w_mem_req;
   assign bus.mem_addr = fetch_pc_q;
   assign bus.mem_size = w_mem_size;
   assign bus.IR       = ir_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.thumb    = thumb_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_prefetch_unit.sv
`default_nettype none
// ============================================================================
// tb_cpu_prefetch_unit : directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_cpu_prefetch_unit;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam int          FIFO_DEPTH   = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   cpu_prefetch_if bus ();

   cpu_prefetch_unit #(
      .RESET_VECTOR(RESET_VECTOR),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Memory image: the two halfwords of each word differ so lane selection is visible
   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[17:2] ^ 16'hA55A, a[17:2] ^ 16'h0F0F};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Memory agent: a request completes once it has waited `waits` cycles
   int   waits = 0;
   int   wcnt  = 0;
   assign bus.mem_ready = bus.mem_req && (wcnt >= waits);
   assign bus.mem_rdata = bus.mem_ready ? memword(bus.mem_addr) : 32'hDEAD_BEEF;

   initial begin : agent
      logic pend;
      forever begin
         @(negedge clk);
         pend = bus.mem_req && !bus.mem_ready;
         @(posedge clk);
         #1;
         wcnt = pend ? wcnt + 1 : 0;
      end
   end

   // Reference model: expected fetch stream and instruction queue
   logic [31:0] mq_op[$];
   logic [31:0] mq_pc[$];
   logic [31:0] m_pc, m_target, m_drain_addr, m_ir, m_ir_pc;
   logic [1:0]  m_drain_size;
   logic        m_thumb, m_drain, m_ir_valid;
   logic        m_init = 1'b0;

   always @(negedge clk) begin : compare
      logic        exp_req, done;
      logic [31:0] tgt, w;
      if (reset) begin
         chk("reset_mem_req", bus.mem_req, 1'b0);
         mq_op.delete();
         mq_pc.delete();
         m_pc = RESET_VECTOR; m_target = RESET_VECTOR; m_drain_addr = 0; m_drain_size = 2'b10;
         m_thumb = 0; m_drain = 0; m_ir = 0; m_ir_pc = 0; m_ir_valid = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         exp_req = m_drain || (mq_pc.size() < FIFO_DEPTH);
         chk("mem_req", bus.mem_req, exp_req);
         if (exp_req) begin
            chk("mem_addr", bus.mem_addr, m_drain ? m_drain_addr : m_pc);
            chk("mem_size", bus.mem_size, m_drain ? m_drain_size : (m_thumb ? 2'b01 : 2'b10));
         end
         chk("ir_valid", bus.ir_valid, m_ir_valid);
         chk("IR", bus.IR, m_ir);
         chk("ir_pc", bus.ir_pc, m_ir_pc);
         chk("thumb", bus.thumb, m_thumb);
         done = exp_req && bus.mem_ready;
         if (bus.flush) begin
            tgt = bus.flush_thumb ? (bus.flush_pc & ~32'd1) : (bus.flush_pc & ~32'd3);
            mq_op.delete();
            mq_pc.delete();
            m_ir_valid = 1'b0;
            if (m_drain) begin
               if (done) begin m_drain = 1'b0; m_pc = tgt; end
               else m_target = tgt;
            end else if (exp_req && !done) begin
               m_drain      = 1'b1;
               m_drain_addr = m_pc;
               m_drain_size = m_thumb ? 2'b01 : 2'b10;
               m_target     = tgt;
            end else begin
               m_pc = tgt;
            end
            m_thumb = bus.flush_thumb;
         end else begin
            if (bus.pipeline_advance) begin
               if (mq_pc.size() > 0) begin
                  m_ir       = mq_op.pop_front();
                  m_ir_pc    = mq_pc.pop_front();
                  m_ir_valid = 1'b1;
               end else begin
                  m_ir_valid = 1'b0;
               end
            end
            if (m_drain) begin
               if (done) begin m_drain = 1'b0; m_pc = m_target; end
            end else if (done) begin
               w = memword(m_pc);
               mq_op.push_back(m_thumb ? {16'h0000, (m_pc[1] ? w[31:16] : w[15:0])} : w);
               mq_pc.push_back(m_pc);
               m_pc = m_pc + (m_thumb ? 32'd2 : 32'd4);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin : stimulus
      logic saw_drop, run_ok;
      int   run;
      bus.pipeline_advance = 1'b0;
      bus.flush            = 1'b0;
      bus.flush_pc         = 32'h0;
      bus.flush_thumb      = 1'b0;

      // Reset and zero-wait ARM streaming
      tick();
      @(negedge clk);
      chk("rst_ir_valid", bus.ir_valid, 1'b0);
      chk("rst_IR", bus.IR, 32'h0);
      chk("rst_ir_pc", bus.ir_pc, 32'h0);
      chk("rst_thumb", bus.thumb, 1'b0);
      tick();
      reset = 1'b0;
      bus.pipeline_advance = 1'b1;
      @(negedge clk);
      chk("c1_req", bus.mem_req, 1'b1);
      chk("c1_addr", bus.mem_addr, 32'h0);
      tick(); @(negedge clk);
      chk("c2_ir_valid", bus.ir_valid, 1'b0);
      tick(); @(negedge clk);
      chk("c3_ir_valid", bus.ir_valid, 1'b1);
      chk("c3_ir_pc", bus.ir_pc, 32'h0);
      chk("c3_IR", bus.IR, 32'hA55A_0F0F);
      tick(); @(negedge clk);
      chk("c4_ir_pc", bus.ir_pc, 32'h4);
      chk("c4_IR", bus.IR, 32'hA55B_0F0E);
      repeat (4) tick();

      // Two wait states per fetch
      waits = 2; run = 0; run_ok = 1'b1; saw_drop = 1'b0;
      repeat (24) begin
         @(negedge clk);
         if (!bus.ir_valid) saw_drop = 1'b1;
         if (bus.mem_req) begin
            if (bus.mem_ready) begin
               if (run != 2) run_ok = 1'b0;
               run = 0;
            end else begin
               run++;
            end
         end
         tick();
      end
      chk("wait2_three_cycles", run_ok, 1'b1);
      chk("wait2_ir_valid_drops", saw_drop, 1'b1);

      // Advance held low: fill to depth, then one pop lets exactly one refill
      waits = 0; bus.pipeline_advance = 1'b0;
      bus.flush = 1'b1; bus.flush_pc = 32'h100; bus.flush_thumb = 1'b0;
      tick(); bus.flush = 1'b0;
      @(negedge clk);
      chk("fill_addr0", bus.mem_addr, 32'h100);
      chk("fill_ir_valid", bus.ir_valid, 1'b0);
      tick(); @(negedge clk);
      chk("fill_addr1", bus.mem_addr, 32'h104);
      tick(); @(negedge clk);
      chk("full_req_low", bus.mem_req, 1'b0);
      tick(); @(negedge clk);
      chk("full_req_still_low", bus.mem_req, 1'b0);
      tick(); bus.pipeline_advance = 1'b1;
      tick(); bus.pipeline_advance = 1'b0;
      @(negedge clk);
      chk("pop_ir_pc", bus.ir_pc, 32'h100);
      chk("pop_refill_addr", bus.mem_addr, 32'h108);
      tick(); @(negedge clk);
      chk("refull_req_low", bus.mem_req, 1'b0);

      // Flush while the request at 0x10 is waiting
      waits = 3; bus.pipeline_advance = 1'b1;
      bus.flush = 1'b1; bus.flush_pc = 32'h10;
      tick(); bus.flush = 1'b0;
      @(negedge clk);
      chk("req10_addr", bus.mem_addr, 32'h10);
      chk("req10_waiting", bus.mem_ready, 1'b0);
      tick(); tick();
      bus.flush = 1'b1; bus.flush_pc = 32'h0800_0103;
      tick(); bus.flush = 1'b0; waits = 0;
      @(negedge clk);
      chk("drain_req", bus.mem_req, 1'b1);
      chk("drain_addr_held", bus.mem_addr, 32'h10);
      tick(); @(negedge clk);
      chk("post_drain_addr", bus.mem_addr, 32'h0800_0100);
      tick(); tick(); @(negedge clk);
      chk("post_drain_ir_pc", bus.ir_pc, 32'h0800_0100);
      chk("post_drain_IR", bus.IR, 32'hA51A_0F4F);

      // Thumb flush with halfword lane selection
      bus.flush = 1'b1; bus.flush_pc = 32'h0300_0001; bus.flush_thumb = 1'b1;
      tick(); bus.flush = 1'b0;
      @(negedge clk);
      chk("thumb_size", bus.mem_size, 2'b01);
      chk("thumb_addr0", bus.mem_addr, 32'h0300_0000);
      chk("thumb_state", bus.thumb, 1'b1);
      tick(); @(negedge clk);
      chk("thumb_addr1", bus.mem_addr, 32'h0300_0002);
      tick(); @(negedge clk);
      chk("thumb_IR_lo", bus.IR, 32'h0000_0F0F);
      chk("thumb_ir_pc0", bus.ir_pc, 32'h0300_0000);
      tick(); @(negedge clk);
      chk("thumb_IR_hi", bus.IR, 32'h0000_A55A);

      // Flush and advance together with a full FIFO
      bus.pipeline_advance = 1'b0;
      tick(); tick(); tick();
      @(negedge clk);
      chk("pre_flush_full", bus.mem_req, 1'b0);
      bus.flush = 1'b1; bus.flush_pc = 32'h200; bus.flush_thumb = 1'b0;
      bus.pipeline_advance = 1'b1;
      tick(); bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_wins_ir_valid", bus.ir_valid, 1'b0);
      chk("flush_wins_empty_req", bus.mem_req, 1'b1);
      chk("flush_wins_addr", bus.mem_addr, 32'h200);

      // Reset in the middle of a waiting transfer
      waits = 3;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_req", bus.mem_req, 1'b0);
      tick(); reset = 1'b0;
      @(negedge clk);
      chk("restart_addr", bus.mem_addr, RESET_VECTOR);
      chk("restart_ir_valid", bus.ir_valid, 1'b0);
      waits = 0;
      repeat (6) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
